// File: rtl/dac_stream_tx.sv
// AXI4-Stream sample source for an RFDC DAC: constant, ramp or RAM playback beats,
// started on a SYSREF rising edge after arm and stopped cleanly on request.
module dac_stream_tx #(
  parameter int NSAMP  = 8,
  parameter int RAM_AW = 9
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  sysref_in,
  input  logic                  arm,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [15:0]           const_val,
  input  logic [15:0]           step,
  input  logic [RAM_AW-1:0]     play_last,
  input  logic                  wr_en,
  input  logic [RAM_AW-1:0]     wr_addr,
  input  logic [16*NSAMP-1:0]   wr_data,
  output logic [16*NSAMP-1:0]   m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [1:0]            state_o,
  output logic [31:0]           beat_count
);
  localparam int DW = 16*NSAMP;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  function automatic logic [DW-1:0] fill_const(input logic [15:0] v);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < NSAMP; k++) r[16*k +: 16] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] fill_ramp(input logic [15:0] base, input logic [15:0] inc);
    logic [DW-1:0] r;
    logic [15:0]   acc;
    r   = '0;
    acc = base;
    for (int k = 0; k < NSAMP; k++) begin
      r[16*k +: 16] = acc;
      acc = acc + inc;
    end
    return r;
  endfunction

  function automatic logic [15:0] ramp_stride(input logic [15:0] inc);
    logic [31:0] prod;
    prod = 32'(inc) * 32'(NSAMP);
    return prod[15:0];
  endfunction

  // Reset asserts asynchronously but releases only after two aclk edges.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  state_t              state;
  logic [1:0]          mode_l;
  logic [15:0]         const_l;
  logic [15:0]         step_l;
  logic [15:0]         ramp_base;
  logic [RAM_AW-1:0]   last_l;
  logic [RAM_AW-1:0]   rd_ptr;
  logic [RAM_AW-1:0]   rd_nxt;
  logic                sysref_q;
  logic [DW-1:0]       ram_rd_p0;
  logic [DW-1:0]       beat_nxt;
  logic [DW-1:0]       tdata_p1;
  logic                vld_p1;
  logic                hs;
  logic                sys_edge;
  logic                arm_go;
  logic                load;

  logic [DW-1:0] ram [0:(1<<RAM_AW)-1];

  assign hs       = vld_p1 & m_axis_tready;
  assign sys_edge = sysref_in & ~sysref_q;
  assign arm_go   = (state == S_IDLE) & arm & ~stop;
  assign load     = (state == S_RUN) & ~stop & (~vld_p1 | hs);

  // rd_ptr always names the beat sitting in ram_rd_p0, so the read runs one beat ahead.
  always_comb begin
    rd_nxt = rd_ptr;
    if (arm_go)     rd_nxt = '0;
    else if (load)  rd_nxt = (rd_ptr == last_l) ? '0 : rd_ptr + RAM_AW'(1);
  end

  always_comb begin
    case (mode_l)
      2'd1:    beat_nxt = fill_ramp(ramp_base, step_l);
      2'd2:    beat_nxt = ram_rd_p0;
      default: beat_nxt = fill_const(const_l);
    endcase
  end

  // Stage p0: playback RAM, read-before-write on a same-address collision.
  always_ff @(posedge aclk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
    ram_rd_p0 <= ram[rd_nxt];
  end

  // Stage p1: control FSM and AXIS output register.
  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      vld_p1     <= 1'b0;
      tdata_p1   <= '0;
      beat_count <= '0;
      ramp_base  <= '0;
      rd_ptr     <= '0;
      sysref_q   <= 1'b0;
      mode_l     <= '0;
      const_l    <= '0;
      step_l     <= '0;
      last_l     <= '0;
    end else begin
      sysref_q <= sysref_in;
      rd_ptr   <= rd_nxt;
      if (hs) beat_count <= beat_count + 32'd1;
      if (load) begin
        tdata_p1  <= beat_nxt;
        vld_p1    <= 1'b1;
        ramp_base <= ramp_base + ramp_stride(step_l);
      end
      case (state)
        S_IDLE: begin
          if (arm_go) begin
            mode_l     <= mode;
            const_l    <= const_val;
            step_l     <= step;
            last_l     <= play_last;
            beat_count <= '0;
            ramp_base  <= '0;
            state      <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (stop)          state <= S_IDLE;
          else if (sys_edge) state <= S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            if (hs | ~vld_p1) begin
              state  <= S_IDLE;
              vld_p1 <= 1'b0;
            end else begin
              state  <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (hs) begin
            state  <= S_IDLE;
            vld_p1 <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_p1;
  assign m_axis_tvalid = vld_p1;
  assign state_o       = state;
endmodule

// File: tb/tb_dac_stream_tx.sv
// Scoreboard bench for dac_stream_tx: directed scenarios push expected beats,
// a negedge monitor pops and compares them on every handshake.
module tb_dac_stream_tx;
  localparam int NS = 8;
  localparam int AW = 9;
  localparam int DW = 16*NS;

  logic          aclk = 1'b0;
  logic          reset = 1'b0;
  logic          sysref_in = 1'b0;
  logic          arm = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [15:0]   const_val = 16'h0;
  logic [15:0]   step = 16'h0;
  logic [AW-1:0] play_last = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [1:0]    state_o;
  logic [31:0]   beat_count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q [$];

  dac_stream_tx #(.NSAMP(NS), .RAM_AW(AW)) dut (
    .aclk(aclk), .reset(reset), .sysref_in(sysref_in), .arm(arm), .stop(stop),
    .mode(mode), .const_val(const_val), .step(step), .play_last(play_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .state_o(state_o), .beat_count(beat_count)
  );

  always #5 aclk = ~aclk;

  function automatic logic [DW-1:0] rep(input logic [15:0] v);
    logic [DW-1:0] r;
    for (int k = 0; k < NS; k++) r[16*k +: 16] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] ramp_beat(input int b, input logic [15:0] st);
    logic [DW-1:0] r;
    logic [31:0]   t;
    for (int k = 0; k < NS; k++) begin
      t = (32'(b) * 32'(NS) + 32'(k)) * 32'(st);
      r[16*k +: 16] = t[15:0];
    end
    return r;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pop on handshake, and hold tvalid/tdata across every stall.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge aclk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_tvalid_hold", 32'(m_axis_tvalid), 32'd1);
          chk_data("stall_tdata_hold", m_axis_tdata, prev_data);
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_unexpected: got %h want none", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            chk_data("beat", m_axis_tdata, e);
          end
        end
        prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
        prev_data  = m_axis_tdata;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int pat [5] = '{1, 0, 1, 1, 0};

    // Reset state
    reset = 1'b1;
    tick(3);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk_data("rst_tdata", m_axis_tdata, '0);
    chk("rst_beat_count", beat_count, 32'd0);

    // Arm right after release must be swallowed by the reset synchronizer
    reset = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick(2);
    chk("early_arm_ignored", 32'(state_o), 32'd0);
    tick(3);

    // Playback RAM: RAM[i]=i for 0..2, a marker at 3
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = AW'(i);
      wr_data = (i == 3) ? rep(16'hBEEF) : rep(16'(i));
      tick();
    end
    wr_en = 1'b0;

    // arm+stop together stays IDLE; stop in ARMED returns to IDLE
    arm = 1'b1; stop = 1'b1;
    tick();
    arm = 1'b0; stop = 1'b0;
    chk("arm_stop_idle", 32'(state_o), 32'd0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("armed", 32'(state_o), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_armed_state", 32'(state_o), 32'd0);
    chk("stop_armed_tvalid", 32'(m_axis_tvalid), 32'd0);

    // Ramp, step=1, full rate through the 16-bit wrap
    mode = 2'd1; step = 16'd1; m_axis_tready = 1'b1;
    for (int b = 0; b < 8194; b++) exp_q.push_back(ramp_beat(b, 16'd1));
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("ramp_armed", 32'(state_o), 32'd1);
    sysref_in = 1'b1;
    tick();
    sysref_in = 1'b0;
    chk("ramp_run_state", 32'(state_o), 32'd2);
    chk("ramp_n1_tvalid", 32'(m_axis_tvalid), 32'd0);
    tick();
    chk("ramp_n2_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk_data("ramp_beat0", m_axis_tdata, ramp_beat(0, 16'd1));
    for (int c = 0; c < 10000 && beat_count != 32'd8193; c++) begin
      tick();
      if (beat_count == 32'd100) begin
        mode = 2'd0; const_val = 16'hDEAD; step = 16'd5;
      end
    end
    chk("ramp_reach", beat_count, 32'd8193);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("ramp_stop_state", 32'(state_o), 32'd0);
    chk("ramp_stop_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("ramp_count", beat_count, 32'd8194);
    chk("ramp_q_empty", 32'(exp_q.size()), 32'd0);

    // SYSREF already high at arm, then stop while stalled -> DRAIN
    mode = 2'd0; const_val = 16'h5A5A; m_axis_tready = 1'b0; sysref_in = 1'b1;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("lvl_armed", 32'(state_o), 32'd1);
    chk("lvl_count_clr", beat_count, 32'd0);
    tick(3);
    chk("lvl_no_start", 32'(state_o), 32'd1);
    chk("lvl_no_tvalid", 32'(m_axis_tvalid), 32'd0);
    sysref_in = 1'b0;
    tick(2);
    chk("lvl_still_armed", 32'(state_o), 32'd1);
    exp_q.push_back(rep(16'h5A5A));
    sysref_in = 1'b1;
    tick();
    chk("lvl_run", 32'(state_o), 32'd2);
    tick();
    chk("lvl_tvalid", 32'(m_axis_tvalid), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("drain_state", 32'(state_o), 32'd3);
    tick(2);
    chk("drain_hold_state", 32'(state_o), 32'd3);
    chk("drain_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk_data("drain_tdata", m_axis_tdata, rep(16'h5A5A));
    m_axis_tready = 1'b1;
    tick();
    chk("drain_idle", 32'(state_o), 32'd0);
    chk("drain_tvalid_low", 32'(m_axis_tvalid), 32'd0);
    chk("drain_count", beat_count, 32'd1);
    chk("drain_q_empty", 32'(exp_q.size()), 32'd0);
    sysref_in = 1'b0;
    tick();

    // Playback, play_last=2, tready pattern 1,0,1,1,0
    mode = 2'd2; play_last = AW'(2); m_axis_tready = 1'b0;
    for (int b = 0; b < 9; b++) exp_q.push_back(rep(16'(b % 3)));
    arm = 1'b1;
    tick();
    arm = 1'b0;
    sysref_in = 1'b1;
    tick();
    sysref_in = 1'b0;
    for (int c = 0; c < 200 && beat_count < 32'd8; c++) begin
      m_axis_tready = (pat[c % 5] != 0);
      tick();
    end
    chk("pb_reach", beat_count, 32'd8);
    m_axis_tready = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("pb_drain", 32'(state_o), 32'd3);
    m_axis_tready = 1'b1;
    tick();
    chk("pb_idle", 32'(state_o), 32'd0);
    chk("pb_count", beat_count, 32'd9);
    chk("pb_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-RUN in constant mode, then rearm to show RAM retained
    mode = 2'd0; const_val = 16'h1234;
    for (int b = 0; b < 50; b++) exp_q.push_back(rep(16'h1234));
    arm = 1'b1;
    tick();
    arm = 1'b0;
    sysref_in = 1'b1;
    tick();
    sysref_in = 1'b0;
    tick(6);
    chk("c_run_tvalid", 32'(m_axis_tvalid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rr_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rr_count", beat_count, 32'd0);
    chk("rr_state", 32'(state_o), 32'd0);
    exp_q.delete();
    tick(2);
    reset = 1'b0;
    tick(4);
    mode = 2'd2; play_last = AW'(3);
    exp_q.push_back(rep(16'h0));
    exp_q.push_back(rep(16'h1));
    exp_q.push_back(rep(16'h2));
    exp_q.push_back(rep(16'hBEEF));
    exp_q.push_back(rep(16'h0));
    exp_q.push_back(rep(16'h1));
    arm = 1'b1;
    tick();
    arm = 1'b0;
    sysref_in = 1'b1;
    tick();
    sysref_in = 1'b0;
    for (int c = 0; c < 50 && beat_count != 32'd5; c++) tick();
    chk("ret_reach", beat_count, 32'd5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("ret_idle", 32'(state_o), 32'd0);
    chk("ret_count", beat_count, 32'd6);
    chk("ret_q_empty", 32'(exp_q.size()), 32'd0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
